// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencing controller for the SAMAB CPU datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables and mux selects, and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [2:0]       alu_ops,
  output logic             wb_sel,
  output logic             illegal,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_FUNC = 3'b100;

  state_t           state, state_next;
  logic [CNT_W-1:0] count_q;

  // State register; reset always returns to FETCH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)             count_q <= '0;
    else if (instr_done) count_q <= count_q + 1'b1;
  end

  // Reset forces the visible count to zero while rst is held.
  assign instr_count = rst ? '0 : count_q;

  // Next-state and Mealy output decode; everything is quiet during reset.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned (which would infer a latch).
    state_next = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = PC_INC;
    alu_src_b  = 1'b0;
    alu_ops    = ALU_ADD;
    wb_sel     = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;

    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_next = S_EXEC;
            OP_JMP: begin
              pc_we      = 1'b1;
              pc_src     = PC_JUMP;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
            OP_HALT: begin
              instr_done = 1'b1;
              state_next = S_HALT;
            end
            default: begin
              illegal    = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end

        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              alu_ops    = ALU_FUNC;
              state_next = S_WB;
            end
            OP_ADDI: begin
              alu_src_b  = 1'b1;
              state_next = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_b  = 1'b1;
              state_next = S_MEM;
            end
            OP_BEQ: begin
              alu_ops    = ALU_SUB;
              instr_done = 1'b1;
              state_next = S_FETCH;
              if (alu_zero) begin
                pc_we  = 1'b1;
                pc_src = PC_BRANCH;
              end
            end
            default: state_next = S_FETCH;
          endcase
        end

        S_MEM: begin
          addr_sel = 1'b1;
          if (opcode == OP_SW) begin
            mem_wr = 1'b1;
            if (mem_ready) begin
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
          end else begin
            mem_rd = 1'b1;
            if (mem_ready) begin
              mdr_we     = 1'b1;
              state_next = S_WB;
            end
          end
        end

        S_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          wb_sel     = (opcode == OP_LW);
          state_next = S_FETCH;
        end

        S_HALT: halted = 1'b1;

        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule
